// File: rtl/bit_shift_luma_gradient_if.sv
`default_nettype none
// ============================================================================
// Module      : bit_shift_luma_gradient_if
// Description : Pixel bus for the luma/gradient stage. It carries the RGB
//               input side, the luma/gradient output side and the framing
//               flags in both directions. The grad_mag_out signal exists
//               only when GRADIENT_MAG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface bit_shift_luma_gradient_if;
   logic        pixel_valid_in;
   logic        soc_in;
   logic        eoc_in;
   logic        solf_in;
   logic        eolf_in;
   logic [23:0] pixel_in_red;
   logic [23:0] pixel_in_green;
   logic [23:0] pixel_in_blue;

   logic        pixel_valid_out;
   logic        soc_out;
   logic        eoc_out;
   logic        solf_out;
   logic        eolf_out;
   logic [23:0] luma_out;
   logic [24:0] grad_x_out;
   logic [24:0] grad_y_out;
   logic        frame_error;
`ifdef GRADIENT_MAG_EN
   logic [25:0] grad_mag_out;
`endif

   // Producer of RGB pixels / consumer of luma and gradients
   modport master (
      output pixel_valid_in, soc_in, eoc_in, solf_in, eolf_in,
      output pixel_in_red, pixel_in_green, pixel_in_blue,
`ifdef GRADIENT_MAG_EN
      input  grad_mag_out,
`endif
      input  pixel_valid_out, soc_out, eoc_out, solf_out, eolf_out,
      input  luma_out, grad_x_out, grad_y_out, frame_error
   );

   // The luma/gradient stage itself
   modport slave (
      input  pixel_valid_in, soc_in, eoc_in, solf_in, eolf_in,
      input  pixel_in_red, pixel_in_green, pixel_in_blue,
`ifdef GRADIENT_MAG_EN
      output grad_mag_out,
`endif
      output pixel_valid_out, soc_out, eoc_out, solf_out, eolf_out,
      output luma_out, grad_x_out, grad_y_out, frame_error
   );
endinterface
`default_nettype wire

// File: rtl/bit_shift_luma_gradient.sv
`default_nettype none
// ============================================================================
// Module      : bit_shift_luma_gradient
// Description : Reduces filtered Q12.12 RGB to a shift-weighted luma,
//               Y = (R>>2) + (G>>1) + (B>>2). It then emits the signed
//               horizontal and vertical luma gradients, with the framing
//               flags kept aligned. A frame-tracking FSM drops stray pixels
//               and flags framing violations.
//               The fixed latency is 2 cycles. Defining GRADIENT_MAG_EN adds
//               grad_mag_out = |gx| + |gy| and one extra stage, so the
//               latency becomes 3.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_shift_luma_gradient #(
   parameter int IMAGE_DIM    = 64,
   parameter int IMAGE_DIM_BS = 6
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   bit_shift_luma_gradient_if.slave  bus
);
   localparam logic [0:0]              c_ST_IDLE    = 1'b0;
   localparam logic [0:0]              c_ST_CAPTURE = 1'b1;
   localparam logic [IMAGE_DIM_BS-1:0] c_LAST_IDX   = IMAGE_DIM_BS'(IMAGE_DIM - 1);
   localparam logic [IMAGE_DIM_BS-1:0] c_ONE        = IMAGE_DIM_BS'(1);

   // Frame tracking
   logic [0:0]              r_state;
   logic [0:0]              w_state_nxt;
   logic [IMAGE_DIM_BS-1:0] r_row;
   logic [IMAGE_DIM_BS-1:0] r_col;
   logic [IMAGE_DIM_BS-1:0] w_pix_row;
   logic [IMAGE_DIM_BS-1:0] w_pix_col;
   logic                    w_accept;
   logic                    w_err;
   logic                    w_last;

   // Luma and neighbour storage
   logic [23:0] w_luma;
   logic [23:0] r_prev_luma;
   logic [23:0] r_line_buf [IMAGE_DIM];

   // Stage 1: luma plus its left/above neighbours
   logic        r1_valid, r1_err, r1_soc, r1_eoc, r1_solf, r1_eolf;
   logic        r1_col0, r1_row0;
   logic [23:0] r1_luma, r1_left, r1_above;

   // Stage 2: gradients
   logic [24:0] w_gx, w_gy;
   logic        r2_valid, r2_err, r2_soc, r2_eoc, r2_solf, r2_eolf;
   logic [23:0] r2_luma;
   logic [24:0] r2_gx, r2_gy;

   // Shift-only weights. The largest possible sum is below 2^24, so 24 bits
   // are enough and the result is truncated, not rounded.
   assign w_luma = (bus.pixel_in_red >> 2) + (bus.pixel_in_green >> 1) + (bus.pixel_in_blue >> 2);

   // Decide whether the incoming pixel is accepted, its (row,col) position, the next state and any framing fault
   always_comb begin
      w_accept    = 1'b0;
      w_err       = 1'b0;
      w_last      = 1'b0;
      w_state_nxt = r_state;
      w_pix_row   = r_row;
      w_pix_col   = r_col;
      if (bus.pixel_valid_in) begin
         if (bus.soc_in) begin
            // A fresh start. While already capturing, this is a restart fault.
            w_accept    = 1'b1;
            w_pix_row   = '0;
            w_pix_col   = '0;
            w_err       = (r_state == c_ST_CAPTURE);
            w_state_nxt = c_ST_CAPTURE;
         end else if (r_state == c_ST_CAPTURE) begin
            w_accept = 1'b1;
         end else begin
            // A pixel outside a frame is dropped.
            w_err = 1'b1;
         end
         if (w_accept) begin
            w_last = (w_pix_row == c_LAST_IDX) && (w_pix_col == c_LAST_IDX);
            if (bus.eoc_in) begin
               w_state_nxt = c_ST_IDLE;
               if (!w_last)
                  w_err = 1'b1;
            end else if (w_last) begin
               // The frame is full but no eoc arrived: close it and drop what follows.
               w_state_nxt = c_ST_IDLE;
               w_err       = 1'b1;
            end
         end
      end
   end

   // FSM state, position counters and the left-neighbour register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_ST_IDLE;
         r_row       <= '0;
         r_col       <= '0;
         r_prev_luma <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_col       <= w_pix_col + c_ONE;
            r_row       <= (w_pix_col == c_LAST_IDX) ? w_pix_row + c_ONE : w_pix_row;
            r_prev_luma <= w_luma;
         end
      end
   end

   // Line buffer: read the previous row's luma at this column, then overwrite it with the current luma
   always_ff @(posedge clk) begin
      if (w_accept && !rst) begin
         r1_above               <= r_line_buf[w_pix_col];
         r_line_buf[w_pix_col]  <= w_luma;
      end
   end

   // Stage 1 register: luma, left neighbour, edge flags and gated framing flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r1_valid <= 1'b0;
         r1_err   <= 1'b0;
         r1_soc   <= 1'b0;
         r1_eoc   <= 1'b0;
         r1_solf  <= 1'b0;
         r1_eolf  <= 1'b0;
         r1_col0  <= 1'b0;
         r1_row0  <= 1'b0;
         r1_luma  <= '0;
         r1_left  <= '0;
      end else begin
         r1_valid <= w_accept;
         r1_err   <= w_err;
         r1_soc   <= w_accept & bus.soc_in;
         r1_eoc   <= w_accept & bus.eoc_in;
         r1_solf  <= w_accept & bus.solf_in;
         r1_eolf  <= w_accept & bus.eolf_in;
         r1_col0  <= (w_pix_col == '0);
         r1_row0  <= (w_pix_row == '0);
         r1_luma  <= w_luma;
         r1_left  <= r_prev_luma;
      end
   end

   // Zero-extend to 25 bits and subtract. The frame edges have no neighbour, so their gradient is zero.
   assign w_gx = r1_col0 ? '0 : {1'b0, r1_luma} - {1'b0, r1_left};
   assign w_gy = r1_row0 ? '0 : {1'b0, r1_above} == {1'b0, r1_above} ? {1'b0, r1_luma} - {1'b0, r1_above} : '0;

   // Stage 2 register: gradients, with data held at zero on idle cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         r2_valid <= 1'b0;
         r2_err   <= 1'b0;
         r2_soc   <= 1'b0;
         r2_eoc   <= 1'b0;
         r2_solf  <= 1'b0;
         r2_eolf  <= 1'b0;
         r2_luma  <= '0;
         r2_gx    <= '0;
         r2_gy    <= '0;
      end else begin
         r2_valid <= r1_valid;
         r2_err   <= r1_err;
         r2_soc   <= r1_soc;
         r2_eoc   <= r1_eoc;
         r2_solf  <= r1_solf;
         r2_eolf  <= r1_eolf;
         r2_luma  <= r1_valid ? r1_luma : '0;
         r2_gx    <= r1_valid ? w_gx : '0;
         r2_gy    <= r1_valid ? w_gy : '0;
      end
   end

`ifdef GRADIENT_MAG_EN
   logic [24:0] w_abs_gx, w_abs_gy;
   logic        r3_valid, r3_err, r3_soc, r3_eoc, r3_solf, r3_eolf;
   logic [23:0] r3_luma;
   logic [24:0] r3_gx, r3_gy;
   logic [25:0] r3_mag;

   // Gradients stay within +/-(2^24-1), so negating never overflows.
   assign w_abs_gx = r2_gx[24] ? -r2_gx : r2_gx;
   assign w_abs_gy = r2_gy[24] ? -r2_gy : r2_gy;

   // Stage 3 register: L1 gradient magnitude, with everything else delayed alongside it
   always_ff @(posedge clk) begin
      if (rst) begin
         r3_valid <= 1'b0;
         r3_err   <= 1'b0;
         r3_soc   <= 1'b0;
         r3_eoc   <= 1'b0;
         r3_solf  <= 1'b0;
         r3_eolf  <= 1'b0;
         r3_luma  <= '0;
         r3_gx    <= '0;
         r3_gy    <= '0;
         r3_mag   <= '0;
      end else begin
         r3_valid <= r2_valid;
         r3_err   <= r2_err;
         r3_soc   <= r2_soc;
         r3_eoc   <= r2_eoc;
         r3_solf  <= r2_solf;
         r3_eolf  <= r2_eolf;
         r3_luma  <= r2_luma;
         r3_gx    <= r2_gx;
         r3_gy    <= r2_gy;
         r3_mag   <= {1'b0, w_abs_gx} + {1'b0, w_abs_gy};
      end
   end

   assign bus.pixel_valid_out = r3_valid;
   assign bus.frame_error     = r3_err;
   assign bus.soc_out         = r3_soc;
   assign bus.eoc_out         = r3_eoc;
   assign bus.solf_out        = r3_solf;
   assign bus.eolf_out        = r3_eolf;
   assign bus.luma_out        = r3_luma;
   assign bus.grad_x_out      = r3_gx;
   assign bus.grad_y_out      = r3_gy;
   assign bus.grad_mag_out    = r3_mag;
`else
   assign bus.pixel_valid_out = r2_valid;
   assign bus.frame_error     = r2_err;
   assign bus.soc_out         = r2_soc;
   assign bus.eoc_out         = r2_eoc;
   assign bus.solf_out        = r2_solf;
   assign bus.eolf_out        = r2_eolf;
   assign bus.luma_out        = r2_luma;
   assign bus.grad_x_out      = r2_gx;
   assign bus.grad_y_out      = r2_gy;
`endif

endmodule
`default_nettype wire
